mips_mem_arbiter: RTL and testbench
===================================

// Module: mips_mem_arbiter
// PURPOSE
//   Shares one single-port memory between the Harvard CPU's instruction-fetch and data ports.
//   Sits between mips_cpu_harvard and a unified memory with variable wait states.
//   Arbitration: data has priority, with an anti-starvation guard for fetch.
//   Each access is sequenced through a request/ack handshake.
// PARAMETERS
//   DATA_BURST_MAX  4    consecutive data grants allowed while instr_req is pending
//   WAIT_TIMEOUT    255  max cycles mem_waitrequest may stay high before abort (>=1)
// PORTS
//   clk              in   1   rising-edge clock
//   reset            in   1   asynchronous, active-low reset
//   instr_req        in   1   fetch request; held until instr_ack
//   instr_address    in   32  fetch address; stable while instr_req high
//   instr_readdata   out  32  fetched word; valid while instr_ack high
//   instr_ack        out  1   one-cycle completion pulse for fetch
//   data_read        in   1   data read request; held until data_ack
//   data_write       in   1   data write request; held until data_ack
//   data_address     in   32  data address; stable while request high
//   data_writedata   in   32  store data
//   data_readdata    out  32  load data; valid while data_ack high
//   data_ack         out  1   one-cycle completion pulse for data
//   bus_error        out  1   high with an ack when that access timed out
//   mem_address      out  32  shared memory address
//   mem_read         out  1   memory read strobe
//   mem_write        out  1   memory write strobe
//   mem_writedata    out  32  memory write data
//   mem_readdata     in   32  memory read data; sampled when mem_waitrequest low
//   mem_waitrequest  in   1   memory stall; command held while high
//   busy             out  1   high in any state other than IDLE
// BEHAVIOUR
//   Reset (reset=0, asynchronous): state=IDLE; all outputs 0; burst counter 0; timeout counter 0.
//   States: IDLE, I_ACC, D_ACC, RESP. All outputs are registered.
//   IDLE:
//     - data_read|data_write -> D_ACC, unless the burst counter == DATA_BURST_MAX and instr_req=1.
//     - Otherwise, instr_req -> I_ACC.
//     - No requests -> stay in IDLE.
//   Grant load: on entering an ACC state, load mem_address, mem_writedata and the strobe.
//     - data_write and data_read both high: write wins, read is ignored.
//   Burst counter:
//     - Increments on each D_ACC grant made while instr_req=1; saturates at DATA_BURST_MAX.
//     - Clears on any I_ACC grant.
//     - Clears on a D_ACC grant made while instr_req=0.
//   ACC states: strobe and address are held constant while mem_waitrequest=1.
//   Completion: a rising edge with mem_waitrequest=0 moves to RESP.
//     - Strobe drops.
//     - The matching readdata is captured from mem_readdata (writes leave data_readdata unchanged).
//     - The matching ack goes high for exactly one cycle.
//   Timeout: WAIT_TIMEOUT consecutive edges with mem_waitrequest=1 move to RESP.
//     - Ack and bus_error both high; readdata = 0.
//   RESP -> IDLE unconditionally. Requests are ignored in RESP.
//     - The requester must drop req in the RESP cycle, or it is re-granted next time in IDLE.
//   Latency: with zero wait states, req seen at edge 1 -> strobe in cycle 1 -> ack in cycle 2.
//     - Minimum 3 cycles per access, including RESP.
//   Never more than one strobe high at once. instr_ack and data_ack are never high together.
//   Reset during ACC: strobes and acks drop immediately; the in-flight access is discarded, no ack.
// TESTING
//   1. Fetch only, no waits: instr_req, addr 0xBFC00000, mem_readdata 0x24420001.
//      -> mem_read in cycle 1; instr_ack=1 and instr_readdata=0x24420001 in cycle 2; busy low in cycle 3.
//   2. Simultaneous fetch and data write, addr 0x00000010, data 0xCAFEF00D.
//      -> data granted first with mem_write=1; fetch is granted in the IDLE after RESP.
//   3. Starvation: data_read held continuously with instr_req high.
//      -> 4 data acks, then 1 instr_ack, then data resumes.
//   4. Wait states: mem_waitrequest high for 3 cycles on a read of 0x20.
//      -> strobe and address held 4 cycles; data_ack exactly one cycle after waitrequest falls.
//   5. Timeout with WAIT_TIMEOUT=8, waitrequest stuck high.
//      -> after 8 edges, data_ack=1, bus_error=1, data_readdata=0; then IDLE.
//   6. Reset low mid-I_ACC.
//      -> mem_read=0 and busy=0 with no clock edge; no instr_ack after reset is released.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// Shares one single-port, variable-wait-state memory between the CPU fetch and data ports.
// Data has priority; a burst counter guarantees a pending fetch a slot after DATA_BURST_MAX data grants.
module mips_mem_arbiter #(
  parameter int unsigned DATA_BURST_MAX = 4,
  parameter int unsigned WAIT_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  output logic        instr_ack,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        data_ack,
  output logic        bus_error,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        busy
);

  localparam int unsigned BW = (DATA_BURST_MAX < 1) ? 1 : $clog2(DATA_BURST_MAX + 1);
  localparam int unsigned TW = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT);
  localparam logic [BW-1:0] BURST_MAX = BW'(DATA_BURST_MAX);
  localparam logic [TW-1:0] TCNT_LAST = TW'(WAIT_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC, RESP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [31:0]   instr_readdata_d, data_readdata_d, mem_address_d, mem_writedata_d;
  logic          instr_ack_d, data_ack_d, bus_error_d, mem_read_d, mem_write_d, busy_d;
  logic          data_req, fetch_forced;

  assign data_req     = data_read | data_write;
  assign fetch_forced = instr_req && (burst_q == BURST_MAX);

  always_comb begin
    state_d          = state_q;
    burst_d          = burst_q;
    tcnt_d           = tcnt_q;
    instr_readdata_d = instr_readdata;
    data_readdata_d  = data_readdata;
    mem_address_d    = mem_address;
    mem_writedata_d  = mem_writedata;
    mem_read_d       = mem_read;
    mem_write_d      = mem_write;
    instr_ack_d      = 1'b0;
    data_ack_d       = 1'b0;
    bus_error_d      = 1'b0;

    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (data_req && !fetch_forced) begin
          state_d         = D_ACC;
          mem_address_d   = data_address;
          mem_writedata_d = data_writedata;
          mem_write_d     = data_write;
          mem_read_d      = ~data_write;
          // Only grants that overtake a waiting fetch count towards the burst limit.
          if (!instr_req)
            burst_d = '0;
          else if (burst_q != BURST_MAX)
            burst_d = burst_q + 1'b1;
        end else if (instr_req) begin
          state_d         = I_ACC;
          mem_address_d   = instr_address;
          mem_writedata_d = '0;
          mem_write_d     = 1'b0;
          mem_read_d      = 1'b1;
          burst_d         = '0;
        end
      end

      I_ACC, D_ACC: begin
        if (!mem_waitrequest || tcnt_q == TCNT_LAST) begin
          state_d     = RESP;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          bus_error_d = mem_waitrequest;
          if (state_q == I_ACC) begin
            instr_ack_d      = 1'b1;
            instr_readdata_d = mem_waitrequest ? '0 : mem_readdata;
          end else begin
            data_ack_d = 1'b1;
            if (mem_waitrequest)
              data_readdata_d = '0;
            else if (mem_read)
              data_readdata_d = mem_readdata;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        tcnt_d  = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      burst_q        <= '0;
      tcnt_q         <= '0;
      instr_readdata <= '0;
      instr_ack      <= 1'b0;
      data_readdata  <= '0;
      data_ack       <= 1'b0;
      bus_error      <= 1'b0;
      mem_address    <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      burst_q        <= burst_d;
      tcnt_q         <= tcnt_d;
      instr_readdata <= instr_readdata_d;
      instr_ack      <= instr_ack_d;
      data_readdata  <= data_readdata_d;
      data_ack       <= data_ack_d;
      bus_error      <= bus_error_d;
      mem_address    <= mem_address_d;
      mem_read       <= mem_read_d;
      mem_write      <= mem_write_d;
      mem_writedata  <= mem_writedata_d;
      busy           <= busy_d;
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: fetch, priority, anti-starvation, wait states, timeout, reset.
module tb_mips_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        instr_ack;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        data_ack;
  logic        bus_error;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic        busy;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  mips_mem_arbiter #(
    .DATA_BURST_MAX(4),
    .WAIT_TIMEOUT  (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_req      (instr_req),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .instr_ack      (instr_ack),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_address   (data_address),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata),
    .data_ack       (data_ack),
    .bus_error      (bus_error),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .mem_waitrequest(mem_waitrequest),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  logic [1:0] seq [6];
  int unsigned nack;
  int unsigned clash;

  initial begin
    reset = 1'b0;
    instr_req = 1'b0; instr_address = '0;
    data_read = 1'b0; data_write = 1'b0; data_address = '0; data_writedata = '0;
    mem_readdata = '0; mem_waitrequest = 1'b0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_acks", {29'd0, instr_ack, data_ack, bus_error}, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    reset = 1'b1;
    tick();

    // 1: fetch only, zero wait states
    instr_req = 1'b1; instr_address = 32'hBFC0_0000; mem_readdata = 32'h2442_0001;
    tick();
    chk("t1_mem_read", {31'd0, mem_read}, 32'd1);
    chk("t1_addr", mem_address, 32'hBFC0_0000);
    chk("t1_ack_early", {31'd0, instr_ack}, 32'd0);
    tick();
    chk("t1_ack", {31'd0, instr_ack}, 32'd1);
    chk("t1_rdata", instr_readdata, 32'h2442_0001);
    chk("t1_strobe_drop", {31'd0, mem_read}, 32'd0);
    instr_req = 1'b0;
    tick();
    chk("t1_ack_pulse", {31'd0, instr_ack}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);

    // 2: simultaneous fetch and data write; data goes first
    instr_req = 1'b1; instr_address = 32'h0000_0100;
    data_write = 1'b1; data_address = 32'h0000_0010; data_writedata = 32'hCAFE_F00D;
    mem_readdata = 32'h1234_5678;
    tick();
    chk("t2_wr_strobe", {30'd0, mem_read, mem_write}, 32'd1);
    chk("t2_wr_addr", mem_address, 32'h0000_0010);
    chk("t2_wr_data", mem_writedata, 32'hCAFE_F00D);
    tick();
    chk("t2_data_ack", {30'd0, instr_ack, data_ack}, 32'd1);
    chk("t2_wr_rdata_kept", data_readdata, 32'd0);
    data_write = 1'b0;
    tick();
    chk("t2_resp_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("t2_fetch_strobe", {30'd0, mem_read, mem_write}, 32'd2);
    chk("t2_fetch_addr", mem_address, 32'h0000_0100);
    tick();
    chk("t2_fetch_ack", {30'd0, instr_ack, data_ack}, 32'd2);
    chk("t2_fetch_rdata", instr_readdata, 32'h1234_5678);
    instr_req = 1'b0;
    tick();

    // 3: starvation guard; data_read held throughout
    instr_req = 1'b1; instr_address = 32'h0000_0200;
    data_read = 1'b1; data_address = 32'h0000_0040; mem_readdata = 32'h1111_1111;
    nack = 0; clash = 0;
    for (int i = 0; i < 6; i++) seq[i] = 2'd0;
    for (int i = 0; i < 18; i++) begin
      tick();
      if ((instr_ack && data_ack) || (mem_read && mem_write)) clash++;
      if ((instr_ack || data_ack) && nack < 6) begin
        seq[nack] = {instr_ack, data_ack};
        nack++;
      end
      if (instr_ack) instr_req = 1'b0;
    end
    data_read = 1'b0;
    chk("t3_ack_count", nack, 32'd6);
    chk("t3_exclusive", clash, 32'd0);
    chk("t3_d0", {30'd0, seq[0]}, 32'd1);
    chk("t3_d3", {30'd0, seq[3]}, 32'd1);
    chk("t3_fetch_5th", {30'd0, seq[4]}, 32'd2);
    chk("t3_data_resumes", {30'd0, seq[5]}, 32'd1);
    chk("t3_rdata", data_readdata, 32'h1111_1111);
    chk("t3_idle", {31'd0, busy}, 32'd0);
    tick();

    // 4: three wait states on a read of 0x20
    data_read = 1'b1; data_address = 32'h0000_0020; mem_readdata = 32'h0BAD_BEEF;
    mem_waitrequest = 1'b1;
    tick();
    chk("t4_c1_strobe", {31'd0, mem_read}, 32'd1);
    tick();
    tick();
    chk("t4_c3_addr", mem_address, 32'h0000_0020);
    tick();
    mem_waitrequest = 1'b0;
    chk("t4_c4_strobe", {31'd0, mem_read}, 32'd1);
    chk("t4_c4_noack", {31'd0, data_ack}, 32'd0);
    tick();
    chk("t4_ack", {31'd0, data_ack}, 32'd1);
    chk("t4_rdata", data_readdata, 32'h0BAD_BEEF);
    chk("t4_strobe_drop", {31'd0, mem_read}, 32'd0);
    data_read = 1'b0;
    tick();
    chk("t4_ack_pulse", {31'd0, data_ack}, 32'd0);

    // 5: timeout after 8 stalled edges
    data_read = 1'b1; data_address = 32'h0000_0030; mem_readdata = 32'hFFFF_FFFF;
    mem_waitrequest = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("t5_edge7_noack", {31'd0, data_ack}, 32'd0);
    chk("t5_edge7_strobe", {31'd0, mem_read}, 32'd1);
    tick();
    chk("t5_ack_err", {30'd0, data_ack, bus_error}, 32'd3);
    chk("t5_rdata_zero", data_readdata, 32'd0);
    chk("t5_strobe_drop", {31'd0, mem_read}, 32'd0);
    data_read = 1'b0; mem_waitrequest = 1'b0;
    tick();
    chk("t5_err_pulse", {31'd0, bus_error}, 32'd0);
    chk("t5_idle", {31'd0, busy}, 32'd0);

    // 6: asynchronous reset mid-fetch
    instr_req = 1'b1; instr_address = 32'h0000_0400; mem_waitrequest = 1'b1;
    tick();
    chk("t6_strobe", {31'd0, mem_read}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_strobe", {31'd0, mem_read}, 32'd0);
    chk("t6_async_busy", {31'd0, busy}, 32'd0);
    instr_req = 1'b0; mem_waitrequest = 1'b0;
    tick();
    reset = 1'b1;
    nack = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (instr_ack) nack++;
    end
    chk("t6_no_ack", nack, 32'd0);
    chk("t6_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
